c2s_pkt_fifo: RTL and testbench
===============================

Name: c2s_pkt_fifo

Overview:
- Store-and-forward AXI-Stream packet buffer between the C2S traffic generator's master stream and the PCIe wrapper's C2S channel input.
- Absorbs generator bursts, decouples them from PCIe backpressure and presents only complete packets downstream.
- Falls back to cut-through when a packet is larger than the buffer, so it never deadlocks.
- Exposes occupancy and packet counters for the tester's register file.

Parameters:
- DATA_WIDTH, 128, stream data width in bits; multiple of 32.
- DEPTH, 512, buffer depth in beats; power of two, at least 4.
- STORE_FWD, 1, 1 = store-and-forward, 0 = pure cut-through.

Ports:
- s_axi_clk  in  1  single clock for all interfaces.
- s_axi_rst  in  1  asynchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tkeep  in  DATA_WIDTH/32  dword enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  33  sideband, passed through unchanged.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  buffer not full.
- m_axis_tdata  out  DATA_WIDTH  downstream data.
- m_axis_tkeep  out  DATA_WIDTH/32  dword enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tuser  out  33  sideband.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- fill_level  out  $clog2(DEPTH)+1  beats held, including the output register.
- pkt_count  out  $clog2(DEPTH)+1  complete packets held.
- cut_through_evt  out  1  one-cycle pulse when the oversize fallback engages.

Behaviour:
- Reset (asynchronous, s_axi_rst=1):
  - Pointers, fill_level, pkt_count, cut_through_evt, m_axis_tvalid, m_axis_tlast = 0.
  - m_axis_tdata, m_axis_tkeep, m_axis_tuser = 0.
  - s_axis_tready = 0 during reset, 1 from the first clock edge after release.
- Reset mid-packet discards all contents with no partial output. Release is synchronous to s_axi_clk.
- Storage: dual-pointer RAM of DEPTH entries, each holding {tuser, tlast, tkeep, tdata}. Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
- Write: a beat is accepted when s_axis_tvalid && s_axis_tready.
- s_axis_tready = !(RAM full). It is a registered lookahead and must not combinationally depend on s_axis_tvalid.
- Output stage: one registered FWFT stage. m_axis_* hold stable while tvalid && !tready (AXI-S rule).
  - Refill on the same cycle the current beat is consumed; gap-free streaming at 1 beat/cycle.
- Read eligibility, STORE_FWD=1: a read is issued only when pkt_count_ram > 0 (a complete packet is in RAM) or the cut-through latch is set.
- Read eligibility, STORE_FWD=0: a read is issued whenever the RAM is non-empty.
- Latency, cut-through: beat accepted at cycle N -> m_axis_tvalid at N+2.
- Latency, store-and-forward: first beat appears at N+2, where N is the tlast write cycle.
- pkt_count: +1 on tlast write, -1 on tlast output handshake, unchanged when both happen in the same cycle.
- fill_level: +1 on write, -1 on output handshake, unchanged when both happen. Max DEPTH+1.
- Oversize fallback (STORE_FWD=1):
  - Trigger: RAM full && pkt_count_ram == 0 && s_axis_tvalid.
  - Actions: set the cut-through latch and pulse cut_through_evt for exactly 1 cycle.
  - The latch clears when the tlast of that packet is read from RAM.
  - No data is dropped or reordered.
- Simultaneous read and write when full: allowed. The write is accepted only if s_axis_tready was already 1; no same-cycle bypass of full.
- tkeep/tuser pass through unmodified. The block performs no tlast insertion or validity checking.

Test Plan:
1. Single 128 B packet (8 beats, DATA_WIDTH=128), m_axis_tready=1, STORE_FWD=1:
   - m_axis_tvalid first rises 2 cycles after the tlast write.
   - 8 consecutive beats with data unchanged; tlast on beat 8 only.
   - pkt_count goes 0→1→0.
2. Backpressure: three 4-beat packets, m_axis_tready toggled 1/0 every cycle:
   - Output data is held stable on every stalled cycle.
   - 12 beats arrive in order; fill_level returns to 0.
3. Full boundary, DEPTH=16, m_axis_tready=0, five 4-beat packets:
   - s_axis_tready drops after 17 beats (16 RAM + 1 output register); fill_level=17.
   - Releasing tready drains all 20 beats in order.
4. Oversize: DEPTH=16, one 40-beat packet, m_axis_tready=1 after 30 cycles:
   - cut_through_evt pulses once.
   - All 40 beats are delivered with no loss and tlast on beat 40.
   - The following 2-beat packet is handled store-and-forward again.
5. Reset asserted mid-packet (beat 3 of 8):
   - All outputs are 0 immediately (asynchronous).
   - After release, a new 2-beat packet is delivered alone.
6. STORE_FWD=0, one 8-beat packet: the first output beat appears at N+2 after the first write.

Source files
------------

// File: rtl/c2s_pkt_fifo_if.sv
// ----------------------------------------------------------------------------
// c2s_pkt_fifo_if
// AXI-Stream bundle used on both sides of the C2S packet FIFO.
//   tdata  : DATA_WIDTH-bit payload
//   tkeep  : one enable bit per 32-bit dword
//   tlast  : end of packet
//   tuser  : 33-bit sideband, carried through untouched
//   tvalid : source has a beat
//   tready : sink takes the beat
// master drives the payload and tvalid; slave drives tready.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface c2s_pkt_fifo_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 32;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [32:0]           tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/c2s_pkt_fifo.sv
// ----------------------------------------------------------------------------
// c2s_pkt_fifo
// Store-and-forward AXI-Stream packet buffer between the C2S traffic
// generator and the PCIe wrapper C2S input. Whole packets are released
// downstream; a packet larger than the RAM switches the buffer to
// cut-through until that packet's tlast has left the RAM.
//
// Ports:
//   s_axi_clk       : single clock
//   s_axi_rst       : asynchronous active-high reset
//   s_axis          : upstream stream (slave side)
//   m_axis          : downstream stream (master side), one registered FWFT stage
//   fill_level      : beats held, RAM plus output register
//   pkt_count       : complete packets held, RAM plus output register
//   cut_through_evt : one-cycle pulse when the oversize fallback engages
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module c2s_pkt_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 512,
    parameter int STORE_FWD  = 1
) (
    input  logic                     s_axi_clk,
    input  logic                     s_axi_rst,
    c2s_pkt_fifo_if.slave            s_axis,
    c2s_pkt_fifo_if.master           m_axis,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     cut_through_evt
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 32;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = AW + 1;

    typedef struct packed {
        logic [32:0]           tuser;
        logic                  tlast;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic [DATA_WIDTH-1:0] tdata;
    } entry_t;

    entry_t          mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic            in_ready;
    logic [CW-1:0]   pkt_count_ram;    // complete packets still inside the RAM
    logic            ct_latch;         // oversize packet is being cut through
    entry_t          out_q;
    logic            out_valid;

    logic            wr_en, rd_en, out_hs;
    logic            ram_empty, ram_full, rd_eligible, ct_trigger;
    entry_t          rd_entry;

    // NOTE: every signal gets a value on every path through an always_comb;
    // a missed branch would infer a latch.
    always_comb begin
        ram_empty   = (wr_ptr == rd_ptr);
        ram_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_en       = s_axis.tvalid && in_ready;
        out_hs      = out_valid && m_axis.tready;
        rd_entry    = mem[rd_ptr[AW-1:0]];
        rd_eligible = (STORE_FWD == 0) || (pkt_count_ram != '0) || ct_latch;
        // Refill the output register in the same cycle it is drained.
        rd_en       = !ram_empty && rd_eligible && (!out_valid || m_axis.tready);
        // RAM full with no tlast inside: the packet can never complete here.
        ct_trigger  = (STORE_FWD != 0) && !ct_latch && ram_full &&
                      (pkt_count_ram == '0) && s_axis.tvalid;
        wr_ptr_nxt  = wr_ptr + CW'(wr_en);
        rd_ptr_nxt  = rd_ptr + CW'(rd_en);
    end

    // NOTE: the RAM has no reset; the pointers define what is valid, so stale
    // contents after reset are never read.
    always_ff @(posedge s_axi_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
        if (s_axi_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            in_ready        <= 1'b0;
            pkt_count_ram   <= '0;
            pkt_count       <= '0;
            fill_level      <= '0;
            ct_latch        <= 1'b0;
            cut_through_evt <= 1'b0;
            out_valid       <= 1'b0;
            out_q           <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            // Lookahead: tready is the registered "not full" of the next state.
            in_ready      <= ((wr_ptr_nxt ^ rd_ptr_nxt) != {1'b1, {AW{1'b0}}});
            pkt_count_ram <= pkt_count_ram + CW'(wr_en && s_axis.tlast)
                                           - CW'(rd_en && rd_entry.tlast);
            pkt_count     <= pkt_count + CW'(wr_en && s_axis.tlast)
                                       - CW'(out_hs && out_q.tlast);
            fill_level    <= fill_level + CW'(wr_en) - CW'(out_hs);
            cut_through_evt <= ct_trigger;

            if (ct_trigger) begin
                ct_latch <= 1'b1;
            end else if (rd_en && rd_entry.tlast) begin
                ct_latch <= 1'b0;
            end

            if (rd_en) begin
                out_q     <= rd_entry;
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign s_axis.tready = in_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_q.tdata;
    assign m_axis.tkeep  = out_q.tkeep;
    assign m_axis.tlast  = out_q.tlast;
    assign m_axis.tuser  = out_q.tuser;

endmodule

// File: tb/tb_c2s_pkt_fifo.sv
// ----------------------------------------------------------------------------
// tb_c2s_pkt_fifo
// Two instances share one upstream driver: dut_sf (store-and-forward) and
// dut_ct (cut-through, always ready downstream). The cut-through copy only
// sees beats that dut_sf accepts. Accepted beats are queued as expected
// output; independent monitors pop and compare on every output handshake.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_c2s_pkt_fifo;
    localparam int DW    = 128;
    localparam int KW    = DW / 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [32:0]    user;
        logic           last;
        logic [KW-1:0]  keep;
        logic [DW-1:0]  data;
    } beat_t;

    typedef struct packed {
        beat_t b;
        int    cyc;
    } timed_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    c2s_pkt_fifo_if #(.DATA_WIDTH(DW)) sa ();
    c2s_pkt_fifo_if #(.DATA_WIDTH(DW)) ma ();
    c2s_pkt_fifo_if #(.DATA_WIDTH(DW)) sb ();
    c2s_pkt_fifo_if #(.DATA_WIDTH(DW)) mb ();

    logic [CW-1:0] fill_a, pkt_a, fill_b, pkt_b;
    logic          ct_a, ct_b;

    c2s_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(1)) dut_sf (
        .s_axi_clk(clk), .s_axi_rst(rst), .s_axis(sa), .m_axis(ma),
        .fill_level(fill_a), .pkt_count(pkt_a), .cut_through_evt(ct_a));

    c2s_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(0)) dut_ct (
        .s_axi_clk(clk), .s_axi_rst(rst), .s_axis(sb), .m_axis(mb),
        .fill_level(fill_b), .pkt_count(pkt_b), .cut_through_evt(ct_b));

    assign sb.tdata  = sa.tdata;
    assign sb.tkeep  = sa.tkeep;
    assign sb.tlast  = sa.tlast;
    assign sb.tuser  = sa.tuser;
    assign sb.tvalid = sa.tvalid && sa.tready;
    assign mb.tready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t  exp_a[$];
    timed_t exp_b[$];

    int acc_cnt = 0, last_tlast_cyc = 0, pkt_first_cyc = 0;
    int a_out_cnt = 0, rise_cyc = -1, fall_cyc = -1, ct_cnt = 0;
    int b_rise_cyc = -1;
    int ready_mode = 1;   // 0 = low, 1 = high, 2 = toggle every cycle

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event, required one within budget", name);
    endtask

    function automatic beat_t make_beat(input int pkt, input int idx, input int n);
        beat_t b;
        b.data = {32'(pkt), 32'(idx), 32'h0C25_0000 + 32'(idx), ~32'(pkt * 7 + idx)};
        b.keep = (idx == n - 1) ? 4'b0111 : 4'hF;
        b.last = (idx == n - 1);
        b.user = {idx[0], 16'(pkt), 16'(idx)};
        return b;
    endfunction

    // ---------------- clocks / downstream ready ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ma.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ma.tready = 1'b0;
                1:       ma.tready = 1'b1;
                default: ma.tready = ~ma.tready;
            endcase
        end
    end

    // ---------------- monitor: store-and-forward instance ----------------
    logic  prev_valid = 1'b0, prev_ready = 1'b0;
    beat_t prev_beat, a_cur, a_exp;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            a_cur = {ma.tuser, ma.tlast, ma.tkeep, ma.tdata};
            if (ct_a) ct_cnt++;
            if (ma.tvalid && prev_valid && !prev_ready)
                check("a_hold_stable", 256'(a_cur), 256'(prev_beat));
            if (ma.tvalid && !prev_valid) rise_cyc = cyc;
            if (!ma.tvalid && prev_valid) fall_cyc = cyc;
            if (ma.tvalid && ma.tready) begin
                if (exp_a.size() == 0) begin
                    fail("a_unexpected_beat");
                end else begin
                    a_exp = exp_a.pop_front();
                    check("a_beat", 256'(a_cur), 256'(a_exp));
                    a_out_cnt++;
                end
            end
            prev_valid = ma.tvalid;
            prev_ready = ma.tready;
            prev_beat  = a_cur;
        end
    end

    // ---------------- monitor: cut-through instance ----------------
    logic   b_prev_valid = 1'b0;
    beat_t  b_cur;
    timed_t b_exp;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            b_prev_valid = 1'b0;
        end else begin
            b_cur = {mb.tuser, mb.tlast, mb.tkeep, mb.tdata};
            if (mb.tvalid && !b_prev_valid) b_rise_cyc = cyc;
            if (mb.tvalid) begin
                if (exp_b.size() == 0) begin
                    fail("b_unexpected_beat");
                end else begin
                    b_exp = exp_b.pop_front();
                    check("b_beat", 256'(b_cur), 256'(b_exp.b));
                    check("b_latency_cycle", 256'(cyc), 256'(b_exp.cyc));
                end
            end
            b_prev_valid = mb.tvalid;
        end
    end

    // ---------------- driver ----------------
    // Entered and left at posedge + 1.
    task automatic send_beat(input beat_t b);
        int waited;
        waited = 0;
        sa.tdata  = b.data;
        sa.tkeep  = b.keep;
        sa.tlast  = b.last;
        sa.tuser  = b.user;
        sa.tvalid = 1'b1;
        @(negedge clk);
        while (!sa.tready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!sa.tready) begin
            fail("send_timeout");
        end else begin
            check("b_ready_on_accept", 256'(sb.tready), 256'(1));
            exp_a.push_back(b);
            exp_b.push_back('{b: b, cyc: cyc + 2});
            acc_cnt++;
            if (b.last) last_tlast_cyc = cyc;
        end
        @(posedge clk);
        #1;
        sa.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int pkt, input int n);
        for (int i = 0; i < n; i++) begin
            send_beat(make_beat(pkt, i, n));
            if (i == 0) pkt_first_cyc = last_acc_cyc();
        end
    endtask

    // Acceptance of the beat just sent happened one cycle before the current one.
    function automatic int last_acc_cyc();
        return cyc - 1;
    endfunction

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_a.size() != 0 || exp_b.size() != 0 || ma.tvalid) && t < 1000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 1000) fail(name);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        @(negedge clk);
        ready_mode = mode;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "simulation timeout");
    end

    // ---------------- directed sequence ----------------
    int mark, base, ct0;

    initial begin
        sa.tvalid = 1'b0;
        sa.tdata  = '0;
        sa.tkeep  = '0;
        sa.tlast  = 1'b0;
        sa.tuser  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_s_tready", 256'(sa.tready), 256'(0));
        check("rst_m_tvalid", 256'(ma.tvalid), 256'(0));
        check("rst_m_tdata", 256'(ma.tdata), 256'(0));
        check("rst_fill", 256'(fill_a), 256'(0));
        check("rst_pkt_count", 256'(pkt_a), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        check("release_tready_still_0", 256'(sa.tready), 256'(0));
        @(posedge clk);
        #1;
        check("tready_after_first_edge", 256'(sa.tready), 256'(1));
        check("b_tready_after_first_edge", 256'(sb.tready), 256'(1));

        // 1: single 8-beat packet, store-and-forward
        mark = a_out_cnt;
        check("t1_pkt_count_before", 256'(pkt_a), 256'(0));
        send_pkt(1, 8);
        check("t1_pkt_count_after_tlast", 256'(pkt_a), 256'(1));
        wait_idle("t1_drain");
        check("t1_valid_rise_cycle", 256'(rise_cyc), 256'(last_tlast_cyc + 2));
        check("t1_consecutive_beats", 256'(fall_cyc - rise_cyc), 256'(8));
        check("t1_out_count", 256'(a_out_cnt - mark), 256'(8));
        check("t1_pkt_count_end", 256'(pkt_a), 256'(0));
        check("t1_fill_end", 256'(fill_a), 256'(0));

        // 2: backpressure toggling every cycle
        mark = a_out_cnt;
        set_ready(2);
        send_pkt(2, 4);
        send_pkt(3, 4);
        send_pkt(4, 4);
        wait_idle("t2_drain");
        set_ready(1);
        check("t2_out_count", 256'(a_out_cnt - mark), 256'(12));
        check("t2_fill_end", 256'(fill_a), 256'(0));

        // 3: full boundary, output stalled
        set_ready(0);
        mark = a_out_cnt;
        base = acc_cnt;
        fork
            begin
                for (int p = 5; p < 10; p++) send_pkt(p, 4);
            end
            begin
                int t;
                t = 0;
                while (acc_cnt - base < 17 && t < 200) begin
                    t++;
                    @(negedge clk);
                end
                repeat (4) @(negedge clk);
                check("t3_accepted_at_full", 256'(acc_cnt - base), 256'(17));
                check("t3_tready_low", 256'(sa.tready), 256'(0));
                check("t3_fill_17", 256'(fill_a), 256'(17));
                check("t3_pkt_count_4", 256'(pkt_a), 256'(4));
                @(negedge clk);
                ready_mode = 1;
            end
        join
        wait_idle("t3_drain");
        check("t3_out_count", 256'(a_out_cnt - mark), 256'(20));
        check("t3_fill_end", 256'(fill_a), 256'(0));

        // 4: oversize packet falls back to cut-through
        set_ready(0);
        mark = a_out_cnt;
        ct0  = ct_cnt;
        fork
            send_pkt(10, 40);
            begin
                repeat (30) @(posedge clk);
                @(negedge clk);
                ready_mode = 1;
            end
        join
        wait_idle("t4_drain");
        check("t4_ct_pulses", 256'(ct_cnt - ct0), 256'(1));
        check("t4_out_count", 256'(a_out_cnt - mark), 256'(40));
        mark = a_out_cnt;
        send_pkt(11, 2);
        wait_idle("t4_sf_drain");
        check("t4_sf_rise_cycle", 256'(rise_cyc), 256'(last_tlast_cyc + 2));
        check("t4_sf_out_count", 256'(a_out_cnt - mark), 256'(2));
        check("t4_no_extra_pulse", 256'(ct_cnt - ct0), 256'(1));

        // 5: reset mid-packet
        send_beat(make_beat(12, 0, 8));
        send_beat(make_beat(12, 1, 8));
        begin
            beat_t b3;
            b3 = make_beat(12, 2, 8);
            sa.tdata  = b3.data;
            sa.tkeep  = b3.keep;
            sa.tlast  = b3.last;
            sa.tuser  = b3.user;
            sa.tvalid = 1'b1;
        end
        #1;
        rst = 1'b1;
        #1;
        check("t5_a_tvalid", 256'(ma.tvalid), 256'(0));
        check("t5_a_tlast", 256'(ma.tlast), 256'(0));
        check("t5_a_tdata", 256'(ma.tdata), 256'(0));
        check("t5_a_tkeep", 256'(ma.tkeep), 256'(0));
        check("t5_a_tuser", 256'(ma.tuser), 256'(0));
        check("t5_a_fill", 256'(fill_a), 256'(0));
        check("t5_a_pkt_count", 256'(pkt_a), 256'(0));
        check("t5_a_ct_evt", 256'(ct_a), 256'(0));
        check("t5_a_s_tready", 256'(sa.tready), 256'(0));
        check("t5_b_tvalid", 256'(mb.tvalid), 256'(0));
        check("t5_b_tdata", 256'(mb.tdata), 256'(0));
        check("t5_b_fill", 256'(fill_b), 256'(0));
        sa.tvalid = 1'b0;
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_tready_after_release", 256'(sa.tready), 256'(1));
        mark = a_out_cnt;
        send_pkt(13, 2);
        wait_idle("t5_drain");
        check("t5_out_count", 256'(a_out_cnt - mark), 256'(2));
        check("t5_fill_end", 256'(fill_a), 256'(0));

        // 6: pure cut-through latency
        send_pkt(14, 8);
        wait_idle("t6_drain");
        check("t6_b_first_valid_cycle", 256'(b_rise_cyc), 256'(pkt_first_cyc + 2));
        check("t6_b_fill_end", 256'(fill_b), 256'(0));
        check("t6_b_pkt_count_end", 256'(pkt_b), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
